// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes,
// datapath select codes and ALU operation codes.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] A_PC    = 2'd0;
  localparam logic [1:0] A_OLDPC = 2'd1;
  localparam logic [1:0] A_RS1   = 2'd2;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // Request from the FSM to the ALU decoder: fixed operation or funct-driven.
  typedef enum logic [2:0] {
    ALUOP_ADD     = 3'd0,
    ALUOP_SUB     = 3'd1,
    ALUOP_FUNCT_R = 3'd2,
    ALUOP_FUNCT_I = 3'd3,
    ALUOP_PASSB   = 3'd4
  } alu_op_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_LUI);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-control decoder: maps the FSM's ALU request plus
// funct3/funct7[5] onto an ALU operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output logic [3:0] alu_ctrl_o
);

  logic w_is_r;
  logic w_alt;

  // I-type immediates occupy bit 30 except for shifts-right, where it selects SRA.
  assign w_is_r = (alu_op_i == ALUOP_FUNCT_R);
  assign w_alt  = w_is_r ? funct7b5_i : (funct7b5_i && (funct3_i == 3'b101));

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB:   alu_ctrl_o = ALU_SUB;
      ALUOP_PASSB: alu_ctrl_o = ALU_PASSB;
      ALUOP_FUNCT_R, ALUOP_FUNCT_I: begin
        case (funct3_i)
          3'b000:  alu_ctrl_o = (w_is_r && w_alt) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_ctrl_o = ALU_SLL;
          3'b010:  alu_ctrl_o = ALU_SLT;
          3'b011:  alu_ctrl_o = ALU_SLTU;
          3'b100:  alu_ctrl_o = ALU_XOR;
          3'b101:  alu_ctrl_o = w_alt ? ALU_SRA : ALU_SRL;
          3'b110:  alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      default:     alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle RISC-V control unit (FETCH/DECODE/EXEC/MEM/WB/FAULT) with memory wait timeout.
// Optional retired-instruction counter instret_o when CTRL_INSTRET_EN is defined.
module unidad_control_multiciclo
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_we_o,
  output logic        ir_we_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        iord_o,
  output logic        reg_we_o,
  output logic [2:0]  imm_sel_o,
  output logic [1:0]  alu_a_sel_o,
  output logic [1:0]  alu_b_sel_o,
  output logic [3:0]  alu_ctrl_o,
  output logic [1:0]  wb_sel_o,
  output logic        fault_o,
  output logic [2:0]  state_o
`ifdef CTRL_INSTRET_EN
  ,
  output logic [31:0] instret_o
`endif
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_wait_cnt;
  logic       w_timeout;
  logic       w_taken;
  logic       w_is_store;
  alu_op_t    w_alu_op;
  logic [3:0] w_alu_ctrl;
  logic       w_pc_we, w_ir_we, w_mem_req, w_mem_we, w_iord, w_reg_we, w_fault;
  logic [2:0] w_imm_sel;
  logic [1:0] w_alu_a_sel, w_alu_b_sel, w_wb_sel;

  assign w_timeout  = (r_wait_cnt == WAIT_LAST);
  assign w_is_store = (opcode_i == OP_STORE);
  // Only beq/bne are decoded; other branch funct3 values fall through as not taken.
  assign w_taken    = ((funct3_i == 3'b000) && zero_i) || ((funct3_i == 3'b001) && !zero_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state)
        r_wait_cnt <= '0;
      else if (((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready_i)
        r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_we     = 1'b0;
    w_ir_we     = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_iord      = 1'b0;
    w_reg_we    = 1'b0;
    w_fault     = 1'b0;
    w_imm_sel   = IMM_I;
    w_alu_a_sel = A_PC;
    w_alu_b_sel = B_RS2;
    w_wb_sel    = WB_ALU;
    w_alu_op    = ALUOP_ADD;
    case (r_state)
      ST_FETCH: begin
        w_mem_req   = 1'b1;
        w_alu_b_sel = B_FOUR;
        if (mem_ready_i) begin
          w_ir_we     = 1'b1;
          w_pc_we     = 1'b1;
          w_state_nxt = ST_DECODE;
        end else if (w_timeout) begin
          w_state_nxt = ST_FAULT;
        end
      end
      ST_DECODE: begin
        w_alu_a_sel = A_OLDPC;
        w_alu_b_sel = B_IMM;
        w_imm_sel   = IMM_B;
        w_state_nxt = is_legal_op(opcode_i) ? ST_EXEC : ST_FAULT;
      end
      ST_EXEC: begin
        case (opcode_i)
          OP_R: begin
            w_alu_a_sel = A_RS1;
            w_alu_op    = ALUOP_FUNCT_R;
            w_state_nxt = ST_WB;
          end
          OP_I: begin
            w_alu_a_sel = A_RS1;
            w_alu_b_sel = B_IMM;
            w_alu_op    = ALUOP_FUNCT_I;
            w_state_nxt = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            w_alu_a_sel = A_RS1;
            w_alu_b_sel = B_IMM;
            w_imm_sel   = w_is_store ? IMM_S : IMM_I;
            w_state_nxt = ST_MEM;
          end
          OP_BRANCH: begin
            w_alu_a_sel = A_RS1;
            w_alu_op    = ALUOP_SUB;
            w_pc_we     = w_taken;
            w_state_nxt = ST_FETCH;
          end
          OP_JAL: begin
            w_alu_a_sel = A_OLDPC;
            w_alu_b_sel = B_IMM;
            w_imm_sel   = IMM_J;
            w_pc_we     = 1'b1;
            w_state_nxt = ST_WB;
          end
          OP_LUI: begin
            w_alu_b_sel = B_IMM;
            w_imm_sel   = IMM_U;
            w_alu_op    = ALUOP_PASSB;
            w_state_nxt = ST_WB;
          end
          default: w_state_nxt = ST_FAULT;
        endcase
      end
      ST_MEM: begin
        // Address is recomputed as rs1+imm so the ALU result stays stable during the access.
        w_mem_req   = 1'b1;
        w_iord      = 1'b1;
        w_mem_we    = w_is_store;
        w_alu_a_sel = A_RS1;
        w_alu_b_sel = B_IMM;
        w_imm_sel   = w_is_store ? IMM_S : IMM_I;
        if (mem_ready_i)
          w_state_nxt = w_is_store ? ST_FETCH : ST_WB;
        else if (w_timeout)
          w_state_nxt = ST_FAULT;
      end
      ST_WB: begin
        w_reg_we    = 1'b1;
        w_wb_sel    = (opcode_i == OP_LOAD) ? WB_MEM :
                      (opcode_i == OP_JAL)  ? WB_PC4 : WB_ALU;
        w_state_nxt = ST_FETCH;
      end
      ST_FAULT: begin
        w_fault     = 1'b1;
        w_state_nxt = ST_FAULT;
      end
      default: w_state_nxt = ST_FAULT;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i   (w_alu_op),
    .funct3_i   (funct3_i),
    .funct7b5_i (funct7b5_i),
    .alu_ctrl_o (w_alu_ctrl)
  );

  // Reset masks every command output immediately, even in the middle of an access.
  assign pc_we_o     = w_pc_we   & ~rst_i;
  assign ir_we_o     = w_ir_we   & ~rst_i;
  assign mem_req_o   = w_mem_req & ~rst_i;
  assign mem_we_o    = w_mem_we  & ~rst_i;
  assign iord_o      = w_iord    & ~rst_i;
  assign reg_we_o    = w_reg_we  & ~rst_i;
  assign fault_o     = w_fault   & ~rst_i;
  assign imm_sel_o   = rst_i ? 3'd0 : w_imm_sel;
  assign alu_a_sel_o = rst_i ? 2'd0 : w_alu_a_sel;
  assign alu_b_sel_o = rst_i ? 2'd0 : w_alu_b_sel;
  assign alu_ctrl_o  = rst_i ? 4'd0 : w_alu_ctrl;
  assign wb_sel_o    = rst_i ? 2'd0 : w_wb_sel;
  assign state_o     = r_state;

`ifdef CTRL_INSTRET_EN
  logic [31:0] r_instret;
  logic        r_retired;

  // An instruction is counted on the fetch that follows its completion.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instret <= '0;
      r_retired <= 1'b0;
    end else begin
      if (((r_state == ST_EXEC) || (r_state == ST_MEM) || (r_state == ST_WB)) &&
          (w_state_nxt == ST_FETCH))
        r_retired <= 1'b1;
      else if ((r_state == ST_FETCH) && (w_state_nxt == ST_DECODE) && r_retired) begin
        r_instret <= r_instret + 32'd1;
        r_retired <= 1'b0;
      end
    end
  end

  assign instret_o = r_instret;
`endif

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Scoreboard bench for unidad_control_multiciclo: directed instruction sequences push
// hand-computed per-cycle output vectors; a negedge monitor pops and compares.
module tb_unidad_control_multiciclo;

  // Packed expectation: {state, pc_we,ir_we,mem_req,mem_we,iord,reg_we, imm, a, b, alu, wb, fault}
  typedef logic [22:0] exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [6:0]  opcode_i = 7'd0;
  logic [2:0]  funct3_i = 3'd0;
  logic        funct7b5_i = 1'b0;
  logic        zero_i = 1'b0;
  logic        mem_ready_i = 1'b0;
  logic        pc_we_o, ir_we_o, mem_req_o, mem_we_o, iord_o, reg_we_o, fault_o;
  logic [2:0]  imm_sel_o, state_o;
  logic [1:0]  alu_a_sel_o, alu_b_sel_o, wb_sel_o;
  logic [3:0]  alu_ctrl_o;
`ifdef CTRL_INSTRET_EN
  logic [31:0] instret_o;
`endif

  unidad_control_multiciclo #(.MEM_WAIT_MAX(15)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .opcode_i    (opcode_i),
    .funct3_i    (funct3_i),
    .funct7b5_i  (funct7b5_i),
    .zero_i      (zero_i),
    .mem_ready_i (mem_ready_i),
    .pc_we_o     (pc_we_o),
    .ir_we_o     (ir_we_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .iord_o      (iord_o),
    .reg_we_o    (reg_we_o),
    .imm_sel_o   (imm_sel_o),
    .alu_a_sel_o (alu_a_sel_o),
    .alu_b_sel_o (alu_b_sel_o),
    .alu_ctrl_o  (alu_ctrl_o),
    .wb_sel_o    (wb_sel_o),
    .fault_o     (fault_o),
    .state_o     (state_o)
`ifdef CTRL_INSTRET_EN
    ,
    .instret_o   (instret_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  exp_t  expq[$];
  string tagq[$];
  int    checks = 0;
  int    errors = 0;
  exp_t  mon_exp;
  exp_t  mon_act;
  string mon_tag;

  function automatic exp_t E(input logic [2:0] st, input logic [5:0] en, input logic [2:0] imm,
                             input logic [1:0] a, input logic [1:0] b, input logic [3:0] alu,
                             input logic [1:0] wb, input logic f);
    return {st, en, imm, a, b, alu, wb, f};
  endfunction

  // Frequently used hand-derived vectors
  localparam exp_t X_RST = 23'd0;
  localparam exp_t X_F0  = {3'd0, 6'b001000, 3'd0, 2'd0, 2'd2, 4'd0, 2'd0, 1'b0};
  localparam exp_t X_F1  = {3'd0, 6'b111000, 3'd0, 2'd0, 2'd2, 4'd0, 2'd0, 1'b0};
  localparam exp_t X_D   = {3'd1, 6'b000000, 3'd2, 2'd1, 2'd1, 4'd0, 2'd0, 1'b0};
  localparam exp_t X_WB  = {3'd4, 6'b000001, 3'd0, 2'd0, 2'd0, 4'd0, 2'd0, 1'b0};
  localparam exp_t X_FLT = {3'd5, 6'b000000, 3'd0, 2'd0, 2'd0, 4'd0, 2'd0, 1'b1};

  task automatic cyc(input logic rst, input logic rdy, input exp_t e, input string tag);
    @(posedge clk_i);
    #1;
    rst_i       = rst;
    mem_ready_i = rdy;
    expq.push_back(e);
    tagq.push_back(tag);
  endtask

  // First FETCH cycle of an instruction, memory answering immediately.
  task automatic start(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input string tag);
    @(posedge clk_i);
    #1;
    rst_i       = 1'b0;
    mem_ready_i = 1'b1;
    opcode_i    = op;
    funct3_i    = f3;
    funct7b5_i  = f7;
    zero_i      = z;
    expq.push_back(X_F1);
    tagq.push_back({tag, "_fetch"});
  endtask

  always @(negedge clk_i) begin
    if (expq.size() != 0) begin
      mon_exp = expq.pop_front();
      mon_tag = tagq.pop_front();
      mon_act = {state_o, pc_we_o, ir_we_o, mem_req_o, mem_we_o, iord_o, reg_we_o,
                 imm_sel_o, alu_a_sel_o, alu_b_sel_o, alu_ctrl_o, wb_sel_o, fault_o};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s actual=%06h required=%06h", mon_tag, mon_act, mon_exp);
      end
    end
  end

  initial begin
    #2 rst_i = 1'b1;
    mem_ready_i = 1'b1;
    cyc(1, 1, X_RST, "reset0");
    cyc(1, 1, X_RST, "reset1");

    // addi x1,x0,5
    start(7'b0010011, 3'b000, 1'b0, 1'b0, "addi");
    cyc(0, 1, X_D, "addi_dec");
    cyc(0, 1, E(3'd2, 6'b0, 3'd0, 2'd2, 2'd1, 4'd0, 2'd0, 1'b0), "addi_ex");
    cyc(0, 1, X_WB, "addi_wb");

    // sub: R-type with funct7[5]
    start(7'b0110011, 3'b000, 1'b1, 1'b0, "sub");
    cyc(0, 1, X_D, "sub_dec");
    cyc(0, 1, E(3'd2, 6'b0, 3'd0, 2'd2, 2'd0, 4'd1, 2'd0, 1'b0), "sub_ex");
    cyc(0, 1, X_WB, "sub_wb");

    // srai: I-type funct3=101 honours funct7[5]
    start(7'b0010011, 3'b101, 1'b1, 1'b0, "srai");
    cyc(0, 1, X_D, "srai_dec");
    cyc(0, 1, E(3'd2, 6'b0, 3'd0, 2'd2, 2'd1, 4'd7, 2'd0, 1'b0), "srai_ex");
    cyc(0, 1, X_WB, "srai_wb");

    // xori with bit30 set: funct7[5] ignored outside funct3=101
    start(7'b0010011, 3'b100, 1'b1, 1'b0, "xori");
    cyc(0, 1, X_D, "xori_dec");
    cyc(0, 1, E(3'd2, 6'b0, 3'd0, 2'd2, 2'd1, 4'd5, 2'd0, 1'b0), "xori_ex");
    cyc(0, 1, X_WB, "xori_wb");

    // sw with memory ready delayed 3 cycles
    start(7'b0100011, 3'b010, 1'b0, 1'b0, "sw");
    cyc(0, 1, X_D, "sw_dec");
    cyc(0, 1, E(3'd2, 6'b0, 3'd1, 2'd2, 2'd1, 4'd0, 2'd0, 1'b0), "sw_ex");
    for (int i = 0; i < 4; i++)
      cyc(0, (i == 3), E(3'd3, 6'b001110, 3'd1, 2'd2, 2'd1, 4'd0, 2'd0, 1'b0), "sw_mem");

    // beq taken / not taken, bne taken
    start(7'b1100011, 3'b000, 1'b0, 1'b1, "beq_t");
    cyc(0, 1, X_D, "beq_t_dec");
    cyc(0, 1, E(3'd2, 6'b100000, 3'd0, 2'd2, 2'd0, 4'd1, 2'd0, 1'b0), "beq_t_ex");
    start(7'b1100011, 3'b000, 1'b0, 1'b0, "beq_n");
    cyc(0, 1, X_D, "beq_n_dec");
    cyc(0, 1, E(3'd2, 6'b000000, 3'd0, 2'd2, 2'd0, 4'd1, 2'd0, 1'b0), "beq_n_ex");
    start(7'b1100011, 3'b001, 1'b0, 1'b0, "bne_t");
    cyc(0, 1, X_D, "bne_t_dec");
    cyc(0, 1, E(3'd2, 6'b100000, 3'd0, 2'd2, 2'd0, 4'd1, 2'd0, 1'b0), "bne_t_ex");

    // jal: PC written in EXEC, link PC+4 in WB
    start(7'b1101111, 3'b000, 1'b0, 1'b0, "jal");
    cyc(0, 1, X_D, "jal_dec");
    cyc(0, 1, E(3'd2, 6'b100000, 3'd4, 2'd1, 2'd1, 4'd0, 2'd0, 1'b0), "jal_ex");
    cyc(0, 1, E(3'd4, 6'b000001, 3'd0, 2'd0, 2'd0, 4'd0, 2'd2, 1'b0), "jal_wb");

    // lui: pass U immediate
    start(7'b0110111, 3'b000, 1'b0, 1'b0, "lui");
    cyc(0, 1, X_D, "lui_dec");
    cyc(0, 1, E(3'd2, 6'b0, 3'd3, 2'd0, 2'd1, 4'd10, 2'd0, 1'b0), "lui_ex");
    cyc(0, 1, X_WB, "lui_wb");

    // lw with one wait cycle
    start(7'b0000011, 3'b010, 1'b0, 1'b0, "lw");
    cyc(0, 1, X_D, "lw_dec");
    cyc(0, 1, E(3'd2, 6'b0, 3'd0, 2'd2, 2'd1, 4'd0, 2'd0, 1'b0), "lw_ex");
    cyc(0, 0, E(3'd3, 6'b001010, 3'd0, 2'd2, 2'd1, 4'd0, 2'd0, 1'b0), "lw_mem_wait");
    cyc(0, 1, E(3'd3, 6'b001010, 3'd0, 2'd2, 2'd1, 4'd0, 2'd0, 1'b0), "lw_mem_rdy");
    cyc(0, 1, E(3'd4, 6'b000001, 3'd0, 2'd0, 2'd0, 4'd0, 2'd1, 1'b0), "lw_wb");

    // lw aborted by reset in the middle of MEM
    start(7'b0000011, 3'b010, 1'b0, 1'b0, "lw_rst");
    cyc(0, 1, X_D, "lw_rst_dec");
    cyc(0, 1, E(3'd2, 6'b0, 3'd0, 2'd2, 2'd1, 4'd0, 2'd0, 1'b0), "lw_rst_ex");
    cyc(0, 0, E(3'd3, 6'b001010, 3'd0, 2'd2, 2'd1, 4'd0, 2'd0, 1'b0), "lw_rst_mem");
    cyc(1, 1, X_RST, "lw_rst_abort");
`ifdef CTRL_INSTRET_EN
    checks++;
    if (instret_o !== 32'd0) begin
      errors++;
      $display("FAIL instret_after_rst actual=%0d required=0", instret_o);
    end
`endif
    cyc(1, 0, X_RST, "lw_rst_hold");

    // Fetch timeout: 15 cycles without mem_ready, then FAULT
    for (int i = 0; i < 15; i++)
      cyc(0, 0, X_F0, "fetch_wait");
    cyc(0, 0, X_FLT, "fetch_timeout");
    cyc(0, 1, X_FLT, "fetch_timeout_sticky");

    // Illegal opcode: FAULT, sticky for 20 cycles whatever mem_ready does
    cyc(1, 0, X_RST, "ill_reset");
    start(7'b0000000, 3'b000, 1'b0, 1'b0, "illegal");
    cyc(0, 1, X_D, "illegal_dec");
    for (int i = 0; i < 20; i++)
      cyc(0, i[0], X_FLT, "illegal_fault");
    cyc(1, 1, X_RST, "fault_reset");
    start(7'b0010011, 3'b000, 1'b0, 1'b0, "after_fault");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && expq.size() != 0; i++)
      @(negedge clk_i);
    #1;
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
